// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU with an iterative shift-add multiply,
// branch/jump resolution, and the execute-to-memory pipeline register.
module execute_stage #(
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      distinct,
  input  logic [31:0]               op1_sub,
  input  logic [31:0]               op2_sub,
  input  logic [4:0]                rs_ex,
  input  logic [4:0]                rt_ex,
  input  logic                      RegWrite,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic                      UARTtoReg,
  input  logic                      RegtoUART,
  input  logic [1:0]                MemtoReg,
  input  logic [1:0]                RegDist,
  input  logic [1:0]                ALUSrcs,
  input  logic                      ALUSrcs2,
  input  logic [3:0]                ALUOp,
  input  logic [1:0]                Branch,
  input  logic [4:0]                rd,
  input  logic [4:0]                sa,
  input  logic [15:0]               immediate,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic                      wb_RegWrite,
  input  logic [4:0]                wb_rw,
  input  logic [31:0]               wb_data,
  output logic                      stall,
  output logic                      distinct_next,
  output logic                      RegWrite_next,
  output logic                      MemWrite_next,
  output logic                      MemRead_next,
  output logic                      UARTtoReg_next,
  output logic                      RegtoUART_next,
  output logic [1:0]                MemtoReg_next,
  output logic [1:0]                RegDist_next,
  output logic [4:0]                rd_next,
  output logic [31:0]               alu_result_next,
  output logic [31:0]               store_data_next,
  output logic [INST_MEM_WIDTH-1:0] pc1_next,
  output logic                      branch_taken_next,
  output logic [INST_MEM_WIDTH-1:0] branch_target_next
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] OP_MUL = 4'd11;

  state_t      state_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;
  logic [4:0]  count_q;
  logic        squash_q;

  logic [31:0] fwdRs;
  logic [31:0] fwdRt;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] aluResult;
  logic [31:0] accStep;
  logic        valid;
  logic        isMul;
  logic        mulStart;
  logic        mulLast;
  logic        capture;
  logic        branchTaken_d;
  logic [INST_MEM_WIDTH-1:0] branchTarget_d;

  // pc and the upper jump-index bits are not needed to resolve anything here.
  logic unusedBits;
  assign unusedBits = ^{pc, inst_index};

  // Own-output forwarding only applies to ALU results, never to loads (MemtoReg != 00).
  always_comb begin
    fwdRs = op1_sub;
    if (rs_ex != 5'd0 && distinct_next && RegWrite_next && MemtoReg_next == 2'b00 && rd_next == rs_ex)
      fwdRs = alu_result_next;
    else if (rs_ex != 5'd0 && wb_RegWrite && wb_rw == rs_ex)
      fwdRs = wb_data;

    fwdRt = op2_sub;
    if (rt_ex != 5'd0 && distinct_next && RegWrite_next && MemtoReg_next == 2'b00 && rd_next == rt_ex)
      fwdRt = alu_result_next;
    else if (rt_ex != 5'd0 && wb_RegWrite && wb_rw == rt_ex)
      fwdRt = wb_data;
  end

  always_comb begin
    op1 = ALUSrcs2 ? {{(32-INST_MEM_WIDTH){1'b0}}, pc1} : fwdRs;
    case (ALUSrcs)
      2'b00:   op2 = fwdRt;
      2'b01:   op2 = {{16{immediate[15]}}, immediate};
      2'b10:   op2 = {16'h0, immediate};
      default: op2 = {27'h0, sa};
    endcase
  end

  always_comb begin
    aluResult = 32'h0;
    case (ALUOp)
      4'd0:  aluResult = op1 + op2;
      4'd1:  aluResult = op1 - op2;
      4'd2:  aluResult = op1 & op2;
      4'd3:  aluResult = op1 | op2;
      4'd4:  aluResult = op1 ^ op2;
      4'd5:  aluResult = ~(op1 | op2);
      4'd6:  aluResult = {31'h0, $signed(op1) < $signed(op2)};
      4'd7:  aluResult = op1 << op2[4:0];
      4'd8:  aluResult = op1 >> op2[4:0];
      4'd9:  aluResult = $unsigned($signed(op1) >>> op2[4:0]);
      4'd10: aluResult = {op2[15:0], 16'h0};
      default: aluResult = 32'h0;
    endcase
  end

  // Only the low word is kept, so plain unsigned shift-add is correct for signed operands too.
  assign accStep  = acc_q + (mplier_q[0] ? mcand_q : 32'h0);

  assign valid    = distinct & ~squash_q;
  assign isMul    = (ALUOp == OP_MUL);
  assign mulStart = (state_q == IDLE) && valid && isMul;
  assign mulLast  = (state_q == BUSY) && (count_q == 5'd31);
  assign stall    = mulStart || ((state_q == BUSY) && !mulLast);
  assign capture  = ((state_q == IDLE) && valid && !isMul) || mulLast;

  always_comb begin
    branchTaken_d = 1'b0;
    if (capture) begin
      case (Branch)
        2'b01:   branchTaken_d = (fwdRs == fwdRt);
        2'b10:   branchTaken_d = (fwdRs != fwdRt);
        2'b11:   branchTaken_d = 1'b1;
        default: branchTaken_d = 1'b0;
      endcase
    end
    branchTarget_d = (Branch == 2'b11) ? inst_index[INST_MEM_WIDTH-1:0]
                                       : pc1 + immediate[INST_MEM_WIDTH-1:0];
  end

  // Multiply FSM, squash tracking and the output register share one clocked block.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q            <= IDLE;
      mcand_q            <= 32'h0;
      mplier_q           <= 32'h0;
      acc_q              <= 32'h0;
      count_q            <= 5'd0;
      squash_q           <= 1'b0;
      distinct_next      <= 1'b0;
      RegWrite_next      <= 1'b0;
      MemWrite_next      <= 1'b0;
      MemRead_next       <= 1'b0;
      UARTtoReg_next     <= 1'b0;
      RegtoUART_next     <= 1'b0;
      MemtoReg_next      <= 2'b00;
      RegDist_next       <= 2'b00;
      rd_next            <= 5'd0;
      alu_result_next    <= 32'h0;
      store_data_next    <= 32'h0;
      pc1_next           <= '0;
      branch_taken_next  <= 1'b0;
      branch_target_next <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mulStart) begin
            mcand_q  <= op1;
            mplier_q <= op2;
            acc_q    <= 32'h0;
            count_q  <= 5'd0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= accStep;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 5'd1;
          if (mulLast) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A redirect must survive a stall so the instruction after it is still dropped.
      if (!stall) squash_q <= branchTaken_d;

      if (capture) begin
        distinct_next      <= 1'b1;
        RegWrite_next      <= RegWrite;
        MemWrite_next      <= MemWrite;
        MemRead_next       <= MemRead;
        UARTtoReg_next     <= UARTtoReg;
        RegtoUART_next     <= RegtoUART;
        MemtoReg_next      <= MemtoReg;
        RegDist_next       <= RegDist;
        rd_next            <= rd;
        alu_result_next    <= mulLast ? accStep : aluResult;
        store_data_next    <= fwdRt;
        pc1_next           <= pc1;
        branch_taken_next  <= branchTaken_d;
        branch_target_next <= branchTarget_d;
      end else begin
        distinct_next      <= 1'b0;
        RegWrite_next      <= 1'b0;
        MemWrite_next      <= 1'b0;
        MemRead_next       <= 1'b0;
        UARTtoReg_next     <= 1'b0;
        RegtoUART_next     <= 1'b0;
        MemtoReg_next      <= 2'b00;
        RegDist_next       <= 2'b00;
        rd_next            <= 5'd0;
        alu_result_next    <= 32'h0;
        store_data_next    <= 32'h0;
        pc1_next           <= '0;
        branch_taken_next  <= 1'b0;
        branch_target_next <= '0;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage: ALU, forwarding, branches, squash and the multiply stall.
module tb_execute_stage;

  localparam int W = 2;

  logic          CLK;
  logic          reset;
  logic          distinct;
  logic [31:0]   op1_sub, op2_sub;
  logic [4:0]    rs_ex, rt_ex;
  logic          RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART;
  logic [1:0]    MemtoReg, RegDist, ALUSrcs;
  logic          ALUSrcs2;
  logic [3:0]    ALUOp;
  logic [1:0]    Branch;
  logic [4:0]    rd, sa;
  logic [15:0]   immediate;
  logic [25:0]   inst_index;
  logic [W-1:0]  pc, pc1;
  logic          wb_RegWrite;
  logic [4:0]    wb_rw;
  logic [31:0]   wb_data;
  logic          stall;
  logic          distinct_next, RegWrite_next, MemWrite_next, MemRead_next, UARTtoReg_next, RegtoUART_next;
  logic [1:0]    MemtoReg_next, RegDist_next;
  logic [4:0]    rd_next;
  logic [31:0]   alu_result_next, store_data_next;
  logic [W-1:0]  pc1_next;
  logic          branch_taken_next;
  logic [W-1:0]  branch_target_next;

  int checks = 0;
  int errors = 0;

  execute_stage #(.INST_MEM_WIDTH(W)) dut (
    .CLK(CLK), .reset(reset), .distinct(distinct),
    .op1_sub(op1_sub), .op2_sub(op2_sub), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .UARTtoReg(UARTtoReg), .RegtoUART(RegtoUART),
    .MemtoReg(MemtoReg), .RegDist(RegDist), .ALUSrcs(ALUSrcs), .ALUSrcs2(ALUSrcs2),
    .ALUOp(ALUOp), .Branch(Branch), .rd(rd), .sa(sa), .immediate(immediate),
    .inst_index(inst_index), .pc(pc), .pc1(pc1),
    .wb_RegWrite(wb_RegWrite), .wb_rw(wb_rw), .wb_data(wb_data),
    .stall(stall), .distinct_next(distinct_next), .RegWrite_next(RegWrite_next),
    .MemWrite_next(MemWrite_next), .MemRead_next(MemRead_next),
    .UARTtoReg_next(UARTtoReg_next), .RegtoUART_next(RegtoUART_next),
    .MemtoReg_next(MemtoReg_next), .RegDist_next(RegDist_next), .rd_next(rd_next),
    .alu_result_next(alu_result_next), .store_data_next(store_data_next),
    .pc1_next(pc1_next), .branch_taken_next(branch_taken_next),
    .branch_target_next(branch_target_next)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ALU operation table: opcode, op1, op2, hand-computed result.
  logic [3:0]  tabOp  [12] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8, 4'd10, 4'd1, 4'd12, 4'd15};
  logic [31:0] tabA   [12] = '{32'hF0F0F0F0, 32'h0000F000, 32'hFFFF0000, 32'h00000000, 32'hFFFFFFFF, 32'h00000001,
                               32'h00000001, 32'h80000000, 32'h00000000, 32'h00000000, 32'h00000005, 32'h00000005};
  logic [31:0] tabB   [12] = '{32'h0FF00FF0, 32'h0000000F, 32'h0F0F0F0F, 32'h0000FFFF, 32'h00000001, 32'hFFFFFFFF,
                               32'h0000001F, 32'h00000004, 32'h1234ABCD, 32'h00000001, 32'h00000005, 32'h00000005};
  logic [31:0] tabExp [12] = '{32'h00F000F0, 32'h0000F00F, 32'hF0F00F0F, 32'hFFFF0000, 32'h00000001, 32'h00000000,
                               32'h80000000, 32'h08000000, 32'hABCD0000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};

  task automatic clearInputs();
    distinct = 0; op1_sub = 0; op2_sub = 0; rs_ex = 0; rt_ex = 0;
    RegWrite = 0; MemWrite = 0; MemRead = 0; UARTtoReg = 0; RegtoUART = 0;
    MemtoReg = 0; RegDist = 0; ALUSrcs = 0; ALUSrcs2 = 0; ALUOp = 0; Branch = 0;
    rd = 0; sa = 0; immediate = 0; inst_index = 0; pc = 0; pc1 = 0;
    wb_RegWrite = 0; wb_rw = 0; wb_data = 0;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] srcs, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rdv, input logic [15:0] imm, input logic [1:0] br,
                               input logic regW);
    distinct = 1; ALUOp = op; ALUSrcs = srcs; ALUSrcs2 = 0; op1_sub = a; op2_sub = b;
    rs_ex = rs; rt_ex = rt; rd = rdv; immediate = imm; Branch = br; RegWrite = regW;
    MemWrite = 0; MemRead = 0; UARTtoReg = 0; RegtoUART = 0; MemtoReg = 0; RegDist = 0;
    sa = 0; inst_index = 0; pc = 0; pc1 = 0;
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (alu_result_next !== 32'h0) begin errors++; $display("[TB] FAIL reset_alu got %h want 0", alu_result_next); end
    checks++; if (distinct_next !== 1'b0) begin errors++; $display("[TB] FAIL reset_distinct got %b want 0", distinct_next); end
    checks++; if (branch_taken_next !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_taken_stall got %b/%b want 0/0", branch_taken_next, stall); end
    @(negedge CLK);
    reset = 0;
  endtask

  task automatic test_add();
    @(negedge CLK);
    applyStimulus(4'd0, 2'b00, 32'd7, 32'hFFFFFFFF, 5'd1, 5'd2, 5'd3, 16'h0, 2'b00, 1'b1);
    MemWrite = 1; MemtoReg = 2'b01; RegDist = 2'b10;
    @(posedge CLK); #1;
    checks++; if (alu_result_next !== 32'd6) begin errors++; $display("[TB] FAIL add_result got %h want 6", alu_result_next); end
    checks++; if (distinct_next !== 1'b1 || rd_next !== 5'd3) begin errors++; $display("[TB] FAIL add_valid_rd got %b/%0d want 1/3", distinct_next, rd_next); end
    checks++; if (MemWrite_next !== 1'b1 || MemtoReg_next !== 2'b01 || RegDist_next !== 2'b10) begin errors++; $display("[TB] FAIL add_ctrl got %b/%b/%b want 1/01/10", MemWrite_next, MemtoReg_next, RegDist_next); end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    applyStimulus(4'd0, 2'b00, 32'd5, 32'd2, 5'd1, 5'd2, 5'd3, 16'h0, 2'b00, 1'b1);
    @(posedge CLK); #1;
    checks++; if (alu_result_next !== 32'd7) begin errors++; $display("[TB] FAIL b2b_first got %h want 7", alu_result_next); end
    @(negedge CLK);
    applyStimulus(4'd1, 2'b01, 32'd0, 32'd0, 5'd3, 5'd0, 5'd4, 16'h0001, 2'b00, 1'b1);
    @(posedge CLK); #1;
    checks++; if (alu_result_next !== 32'd6 || rd_next !== 5'd4) begin errors++; $display("[TB] FAIL b2b_forward got %h/%0d want 6/4", alu_result_next, rd_next); end
  endtask

  task automatic test_wb_forward();
    @(negedge CLK);
    applyStimulus(4'd3, 2'b00, 32'd0, 32'd3, 5'd5, 5'd6, 5'd0, 16'h0, 2'b00, 1'b1);
    wb_RegWrite = 1; wb_rw = 5'd5; wb_data = 32'd100;
    @(posedge CLK); #1;
    checks++; if (alu_result_next !== 32'h67) begin errors++; $display("[TB] FAIL wb_forward got %h want 67", alu_result_next); end
    checks++; if (store_data_next !== 32'd3) begin errors++; $display("[TB] FAIL wb_store_data got %h want 3", store_data_next); end
    @(negedge CLK);
    applyStimulus(4'd0, 2'b01, 32'h10, 32'd0, 5'd0, 5'd0, 5'd9, 16'h0001, 2'b00, 1'b1);
    wb_RegWrite = 1; wb_rw = 5'd0; wb_data = 32'hFF;
    @(posedge CLK); #1;
    checks++; if (alu_result_next !== 32'h11) begin errors++; $display("[TB] FAIL r0_no_forward got %h want 11", alu_result_next); end
    @(negedge CLK);
    wb_RegWrite = 0; wb_rw = 0; wb_data = 0;
  endtask

  task automatic test_alu_ops();
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      applyStimulus(tabOp[i], 2'b00, tabA[i], tabB[i], 5'd0, 5'd0, 5'd9, 16'h0, 2'b00, 1'b1);
      @(posedge CLK); #1;
      checks++;
      if (alu_result_next !== tabExp[i]) begin
        errors++; $display("[TB] FAIL alu_op%0d_row%0d got %h want %h", tabOp[i], i, alu_result_next, tabExp[i]);
      end
    end
  endtask

  task automatic test_operand_select();
    @(negedge CLK);
    applyStimulus(4'd0, 2'b01, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9, 16'h8000, 2'b00, 1'b1);
    @(posedge CLK); #1;
    checks++; if (alu_result_next !== 32'hFFFF8000) begin errors++; $display("[TB] FAIL sext_imm got %h want ffff8000", alu_result_next); end
    @(negedge CLK);
    applyStimulus(4'd0, 2'b10, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9, 16'h8000, 2'b00, 1'b1);
    @(posedge CLK); #1;
    checks++; if (alu_result_next !== 32'h00008000) begin errors++; $display("[TB] FAIL zext_imm got %h want 00008000", alu_result_next); end
    @(negedge CLK);
    applyStimulus(4'd0, 2'b00, 32'h55, 32'h10, 5'd0, 5'd0, 5'd9, 16'h0, 2'b00, 1'b1);
    ALUSrcs2 = 1; pc1 = 2'd3;
    @(posedge CLK); #1;
    checks++; if (alu_result_next !== 32'h13 || pc1_next !== 2'd3) begin errors++; $display("[TB] FAIL pc1_operand got %h/%0d want 13/3", alu_result_next, pc1_next); end
  endtask

  task automatic test_branch_squash();
    @(negedge CLK);
    applyStimulus(4'd1, 2'b00, 32'd9, 32'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 2'b01, 1'b0);
    pc1 = 2'd1;
    @(posedge CLK); #1;
    checks++; if (branch_taken_next !== 1'b1 || branch_target_next !== 2'd0) begin errors++; $display("[TB] FAIL beq_taken got %b/%0d want 1/0", branch_taken_next, branch_target_next); end
    @(negedge CLK);
    applyStimulus(4'd0, 2'b00, 32'd1, 32'd2, 5'd1, 5'd2, 5'd5, 16'h0, 2'b00, 1'b1);
    @(posedge CLK); #1;
    checks++; if (RegWrite_next !== 1'b0 || distinct_next !== 1'b0) begin errors++; $display("[TB] FAIL squash got %b/%b want 0/0", RegWrite_next, distinct_next); end
    @(posedge CLK); #1;
    checks++; if (RegWrite_next !== 1'b1 || alu_result_next !== 32'd3) begin errors++; $display("[TB] FAIL after_squash got %b/%h want 1/3", RegWrite_next, alu_result_next); end
  endtask

  task automatic test_jump();
    @(negedge CLK);
    applyStimulus(4'd0, 2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'h0, 2'b11, 1'b0);
    inst_index = 26'h3FFFF07;
    @(posedge CLK); #1;
    checks++; if (branch_taken_next !== 1'b1 || branch_target_next !== 2'd3) begin errors++; $display("[TB] FAIL jump got %b/%0d want 1/3", branch_taken_next, branch_target_next); end
    @(negedge CLK);
    applyStimulus(4'd0, 2'b00, 32'd1, 32'd1, 5'd0, 5'd0, 5'd5, 16'h0, 2'b00, 1'b1);
    @(posedge CLK); #1;
    checks++; if (distinct_next !== 1'b0) begin errors++; $display("[TB] FAIL jump_squash got %b want 0", distinct_next); end
    @(negedge CLK);
    applyStimulus(4'd1, 2'b00, 32'd1, 32'd1, 5'd1, 5'd2, 5'd0, 16'h1, 2'b10, 1'b0);
    pc1 = 2'd2;
    @(posedge CLK); #1;
    checks++; if (branch_taken_next !== 1'b0 || distinct_next !== 1'b1) begin errors++; $display("[TB] FAIL bne_not_taken got %b/%b want 0/1", branch_taken_next, distinct_next); end
    @(negedge CLK);
    op2_sub = 32'd2;
    @(posedge CLK); #1;
    checks++; if (branch_taken_next !== 1'b1 || branch_target_next !== 2'd3) begin errors++; $display("[TB] FAIL bne_taken got %b/%0d want 1/3", branch_taken_next, branch_target_next); end
    @(negedge CLK);
    clearInputs();
    @(posedge CLK);
  endtask

  task automatic test_mul_stall();
    int  stallCount = 0;
    logic earlyValid = 0;
    @(negedge CLK);
    applyStimulus(4'd11, 2'b00, 32'h00010000, 32'h00030000, 5'd1, 5'd2, 5'd6, 16'h0, 2'b00, 1'b1);
    #1;
    for (int k = 0; k < 40; k++) begin
      if (!stall) break;
      stallCount++;
      @(posedge CLK); #1;
      if (distinct_next !== 1'b0) earlyValid = 1;
    end
    checks++; if (stallCount != 32) begin errors++; $display("[TB] FAIL mul_stall_cycles got %0d want 32", stallCount); end
    checks++; if (earlyValid) begin errors++; $display("[TB] FAIL mul_bubbles got valid output while busy want none"); end
    @(posedge CLK); #1;
    checks++; if (alu_result_next !== 32'h0 || distinct_next !== 1'b1 || rd_next !== 5'd6) begin errors++; $display("[TB] FAIL mul_result got %h/%b/%0d want 0/1/6", alu_result_next, distinct_next, rd_next); end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL mul_restart_stall got %b want 1", stall); end
    @(negedge CLK);
    distinct = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL mul_idle_stall got %b want 0", stall); end
  endtask

  task automatic test_mul_neg_sra();
    @(negedge CLK);
    applyStimulus(4'd11, 2'b00, 32'hFFFFFFFD, 32'd5, 5'd1, 5'd2, 5'd7, 16'h0, 2'b00, 1'b1);
    #1;
    for (int k = 0; k < 40; k++) begin
      if (!stall) break;
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    checks++; if (alu_result_next !== 32'hFFFFFFF1) begin errors++; $display("[TB] FAIL mul_neg got %h want fffffff1", alu_result_next); end
    @(negedge CLK);
    applyStimulus(4'd9, 2'b11, 32'h80000000, 32'd0, 5'd1, 5'd0, 5'd8, 16'h0, 2'b00, 1'b1);
    sa = 5'd4;
    @(posedge CLK); #1;
    checks++; if (alu_result_next !== 32'hF8000000) begin errors++; $display("[TB] FAIL sra got %h want f8000000", alu_result_next); end
  endtask

  task automatic test_reset_during_mul();
    @(negedge CLK);
    applyStimulus(4'd11, 2'b00, 32'd2, 32'd3, 5'd1, 5'd2, 5'd6, 16'h0, 2'b00, 1'b1);
    repeat (11) @(posedge CLK);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL busy_count10_stall got %b want 1", stall); end
    @(negedge CLK);
    reset = 1; distinct = 0;
    @(posedge CLK); #1;
    checks++; if (stall !== 1'b0 || alu_result_next !== 32'h0 || distinct_next !== 1'b0 || RegWrite_next !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_abort got stall=%b alu=%h valid=%b rw=%b want 0/0/0/0", stall, alu_result_next, distinct_next, RegWrite_next);
    end
    @(negedge CLK);
    reset = 0;
    applyStimulus(4'd0, 2'b00, 32'd4, 32'd5, 5'd1, 5'd2, 5'd8, 16'h0, 2'b00, 1'b1);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_stall got %b want 0", stall); end
    @(posedge CLK); #1;
    checks++; if (alu_result_next !== 32'd9 || distinct_next !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_add got %h/%b want 9/1", alu_result_next, distinct_next); end
  endtask

  initial begin
    reset = 1;
    clearInputs();
    test_reset();
    test_add();
    test_back_to_back();
    test_wb_forward();
    test_alu_ops();
    test_operand_select();
    test_branch_squash();
    test_jump();
    test_mul_stall();
    test_mul_neg_sra();
    test_reset_during_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
